// File: rtl/alu_src_ctrl.sv
// Multicycle control sequencer for a MIPS subset (add/sub/and, addi, beq, bne).
// Drives ALU operand selects, ALUOp and the PC/IR/register-file strobes.
module alu_src_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       ALUOutWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic       illegal,
    output logic       ovf_trap,
    output logic [3:0] state_dbg
);
    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_TRAP   = 4'd7
    } state_t;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_ovf;
    logic          r_from_r;
    logic          w_fetch_done;

    assign w_fetch_done = (r_cnt == CW'(MEM_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RST;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_from_r <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            case (r_state)
                S_DECODE: r_ovf <= 1'b0;
                S_EXEC_R: begin
                    r_from_r <= 1'b1;
                    // 'and' cannot overflow, so any flag seen there is ignored
                    r_ovf    <= (funct == 6'h20 || funct == 6'h22) ? overflow : 1'b0;
                end
                S_EXEC_I: begin
                    r_from_r <= 1'b0;
                    r_ovf    <= overflow;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = '0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = OP_IDLE;
        PCSource    = 2'b00;
        PCWrite     = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        ALUOutWrite = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemToReg    = 2'b00;
        illegal     = 1'b0;
        ovf_trap    = 1'b0;
        state_dbg   = reset ? S_RST : r_state;
        if (!reset) begin
            case (r_state)
                S_RST: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemToReg = 2'b10;
                    w_next   = S_FETCH;
                end
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = OP_ADD;
                    if (w_fetch_done) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_DECODE;
                    end else begin
                        w_cnt_next = CW'(r_cnt + 1'b1);
                    end
                end
                S_DECODE: begin
                    ALUSrcB     = 2'b10;
                    ALUOp       = OP_ADD;
                    ALUOutWrite = 1'b1;
                    case (opcode)
                        6'h00:        w_next = S_EXEC_R;
                        6'h08:        w_next = S_EXEC_I;
                        6'h04, 6'h05: w_next = S_BRANCH;
                        default: begin
                            illegal = 1'b1;
                            w_next  = S_TRAP;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    ALUSrcA     = 1'b1;
                    ALUOutWrite = 1'b1;
                    w_next      = S_WB;
                    case (funct)
                        6'h20: ALUOp = OP_ADD;
                        6'h22: ALUOp = OP_SUB;
                        6'h24: ALUOp = OP_AND;
                        default: begin
                            ALUOutWrite = 1'b0;
                            illegal     = 1'b1;
                            w_next      = S_TRAP;
                        end
                    endcase
                end
                S_EXEC_I: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = 2'b11;
                    ALUOp       = OP_ADD;
                    ALUOutWrite = 1'b1;
                    w_next      = S_WB;
                end
                S_WB: begin
                    RegDst   = r_from_r ? 2'b01 : 2'b00;
                    RegWrite = ~r_ovf;
                    ovf_trap = r_ovf;
                    w_next   = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = OP_SUB;
                    PCSource = 2'b01;
                    PCWrite  = (opcode == 6'h04) ? zero : ~zero;
                    w_next   = S_FETCH;
                end
                S_TRAP:  w_next = S_FETCH;
                default: w_next = S_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_src_ctrl.sv
// Randomized bench for alu_src_ctrl: each instruction's cycle-by-cycle control
// word is derived from its class and compared against the DUT.
module tb_alu_src_ctrl;
    localparam int M = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, overflow = 1'b0;
    logic       ALUSrcA, PCWrite, IRWrite, MemRead, ALUOutWrite, RegWrite;
    logic       illegal, ovf_trap;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemToReg;
    logic [2:0] ALUOp;
    logic [3:0] state_dbg;

    int n_chk = 0, n_fail = 0;
    bit irw_seen = 0;

    alu_src_ctrl #(.MEM_WAIT(M)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemRead(MemRead), .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .illegal(illegal),
        .ovf_trap(ovf_trap), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] cw(bit sa, logic [1:0] sb, logic [2:0] op,
                                       logic [1:0] pcs, bit pcw, bit irw, bit mr,
                                       bit aow, bit rw, logic [1:0] rd,
                                       logic [1:0] mtr, bit ill, bit trp);
        return {sa, sb, op, pcs, pcw, irw, mr, aow, rw, rd, mtr, ill, trp};
    endfunction

    function automatic logic [18:0] obs_cw();
        return {ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite, IRWrite, MemRead,
                ALUOutWrite, RegWrite, RegDst, MemToReg, illegal, ovf_trap};
    endfunction

    task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Check one cycle's control word mid-cycle, then move to just after the next edge.
    task automatic cyc(input string tag, input logic [18:0] exp);
        @(negedge clk);
        chk(tag, obs_cw(), exp);
        if (IRWrite) irw_seen = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        zero     = 1'($urandom);
        overflow = 1'($urandom);
    endtask

    task automatic reset_seq(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cyc("reset", '0);
        reset = 1'b0;
        noise();
        cyc("rst_init", cw(0, 2'b00, 3'd0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0));
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit ov, input bit z);
        bit legal_op, legal_fn, eff;
        logic [2:0] aop;
        opcode = op;
        funct  = fn;
        for (int k = 0; k <= M; k++) begin
            noise();
            cyc(k == M ? "fetch_last" : "fetch",
                cw(0, 2'b01, 3'd1, 2'b00, k == M, k == M, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        end
        legal_op = (op == 6'h00 || op == 6'h08 || op == 6'h04 || op == 6'h05);
        noise();
        cyc("decode", cw(0, 2'b10, 3'd1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, !legal_op, 0));
        if (!legal_op) begin
            noise();
            cyc("trap", '0);
            return;
        end
        if (op == 6'h00) begin
            legal_fn = (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
            overflow = ov;
            zero     = 1'($urandom);
            if (!legal_fn) begin
                cyc("exec_r_ill", cw(1, 2'b00, 3'd0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
                noise();
                cyc("trap", '0);
                return;
            end
            aop = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
            cyc("exec_r", cw(1, 2'b00, aop, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
            eff = ov && (fn != 6'h24);
            overflow = ~ov;
            cyc("wb_r", cw(0, 2'b00, 3'd0, 2'b00, 0, 0, 0, 0, !eff, 2'b01, 2'b00, 0, eff));
        end else if (op == 6'h08) begin
            overflow = ov;
            zero     = 1'($urandom);
            cyc("exec_i", cw(1, 2'b11, 3'd1, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
            overflow = ~ov;
            cyc("wb_i", cw(0, 2'b00, 3'd0, 2'b00, 0, 0, 0, 0, !ov, 2'b00, 2'b00, 0, ov));
        end else begin
            zero     = z;
            overflow = 1'($urandom);
            cyc("branch", cw(1, 2'b00, 3'd2, 2'b01, (op == 6'h04) ? z : !z, 0, 0, 0, 0,
                             2'b00, 2'b00, 0, 0));
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        int cls;
        #1;
        reset_seq(3);
        // directed cases
        run_instr(6'h00, 6'h22, 1'b0, 1'b0);
        run_instr(6'h08, 6'h00, 1'b1, 1'b0);
        run_instr(6'h04, 6'h00, 1'b0, 1'b1);
        run_instr(6'h05, 6'h00, 1'b0, 1'b1);
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
        run_instr(6'h00, 6'h24, 1'b1, 1'b0);
        run_instr(6'h00, 6'h21, 1'b0, 1'b0);
        // reset during the 2nd FETCH cycle
        opcode = 6'h00; funct = 6'h20;
        irw_seen = 0;
        cyc("fetch", cw(0, 2'b01, 3'd1, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0));
        reset_seq(1);
        n_chk++;
        if (irw_seen) begin
            n_fail++;
            $display("FAIL midrst_irw: got IRWrite pulse expected none");
        end
        // random instruction stream
        for (int i = 0; i < 60; i++) begin
            cls = $urandom_range(0, 9);
            fn  = 6'($urandom);
            case (cls)
                0, 1, 2: begin
                    op = 6'h00;
                    case ($urandom_range(0, 3))
                        0: fn = 6'h20;
                        1: fn = 6'h22;
                        2: fn = 6'h24;
                        default: ;
                    endcase
                end
                3, 4:    op = 6'h08;
                5, 6:    op = 6'h04;
                7, 8:    op = 6'h05;
                default: op = 6'($urandom_range(9, 63));
            endcase
            run_instr(op, fn, 1'($urandom), 1'($urandom));
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_src_ctrl.md
# alu_src_ctrl

Multicycle control sequencer that drives the ALU operand-select lines (ALUSrcA, ALUSrcB), the ALU operation code, and the PC, IR and register-file write strobes for a subset of the MIPS datapath: R-type add/sub/and, addi, beq and bne. It sits between the instruction register outputs and the datapath muxes. It is the producing end of the ALUSrcB select: every ALUSrcB code is generated here, and only in the states listed below.

## Interface
- MEM_WAIT, default 2: extra memory-latency cycles in the fetch state before the instruction word is valid.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (combinational, current cycle).
- overflow  in  1  ALU signed-overflow flag (combinational, current cycle).
- ALUSrcA  out  1  0 = PC, 1 = regA.
- ALUSrcB  out  2  00 = regB, 01 = constant 4, 10 = branch offset (sign-extended, shifted left 2), 11 = sign-extended immediate.
- ALUOp  out  3  001 add, 010 sub, 011 and; 000 idle.
- PCSource  out  2  00 = ALU result, 01 = ALUOut.
- PCWrite, IRWrite, MemRead, ALUOutWrite, RegWrite  out  1 each  write/read strobes.
- RegDst  out  2  00 = rt, 01 = rd, 10 = register 29.
- MemToReg  out  2  00 = ALUOut, 10 = constant 227.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- ovf_trap  out  1  one-cycle pulse when an arithmetic result is discarded due to overflow.
- state_dbg  out  4  current state encoding.

## Operation
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, WB, BRANCH, TRAP. Outputs are Moore-decoded from the state, except where a signal is stated as conditional below. Any output not listed for a state is 0.
- While reset = 1:
  - State is forced to RST and the fetch counter to 0.
  - All outputs are 0, including RegWrite; state_dbg = RST.
- RST, first cycle after reset falls:
  - RegWrite = 1, RegDst = 10, MemToReg = 10 (register 29 is loaded with 227).
  - Next state is FETCH.
- FETCH:
  - MemRead = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = add. A counter runs 0..MEM_WAIT.
  - On the cycle where counter = MEM_WAIT: IRWrite = 1, PCWrite = 1, PCSource = 00, counter clears, next state is DECODE.
  - On all other FETCH cycles, IRWrite and PCWrite stay 0.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 10, ALUOp = add, ALUOutWrite = 1 (branch target is precomputed).
  - Next state: opcode 0x00 → EXEC_R; 0x08 → EXEC_I; 0x04 or 0x05 → BRANCH; any other opcode → TRAP with illegal = 1.
- EXEC_R:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOutWrite = 1.
  - ALUOp from funct: 0x20 add, 0x22 sub, 0x24 and.
  - Any other funct: ALUOutWrite = 0, illegal = 1, next state TRAP.
  - The overflow flag is latched only for add and sub; it is always 0 for and.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 11, ALUOp = add, ALUOutWrite = 1. The overflow flag is latched.
- WB:
  - MemToReg = 00; RegDst = 01 when coming from EXEC_R, 00 when coming from EXEC_I.
  - RegWrite = ~ovf_latched. When ovf_latched = 1, ovf_trap pulses instead of the write.
  - Next state is FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 00, ALUOp = sub, PCSource = 01.
  - PCWrite = zero for beq, ~zero for bne.
  - Next state is FETCH.
- TRAP: all strobes 0, next state FETCH. The PC has already advanced by 4.
- The overflow latch clears in DECODE and on reset.

## Timing
- Cycles per instruction with MEM_WAIT = M:
  - R-type and addi: M + 4.
  - beq/bne: M + 3.
  - Illegal opcode: M + 3 (DECODE, then TRAP). Illegal funct: M + 4.
- The first FETCH begins 2 cycles after reset falls (one RST cycle).
- Reset asserted in any state, including mid-FETCH with counter ≠ 0: on the next edge state = RST and counter = 0. No strobe is asserted in that reset cycle.
- zero and overflow are sampled only in BRANCH and EXEC states respectively. Their values in other states have no effect.
- illegal and ovf_trap never assert in the same cycle.

## Test plan
- Reset for 3 cycles, then release → one cycle with RegWrite = 1, RegDst = 10, MemToReg = 10; the next cycle has state_dbg = FETCH and MemRead = 1.
- MEM_WAIT = 2, opcode 0x00, funct 0x22, overflow = 0 → IRWrite/PCWrite high only in the 3rd FETCH cycle; EXEC_R shows ALUSrcB = 00 and ALUOp = 010; WB has RegWrite = 1, RegDst = 01; total 6 cycles.
- addi with overflow = 1 in EXEC_I → WB has RegWrite = 0 and ovf_trap = 1 for exactly one cycle; next state FETCH.
- beq with zero = 1, then bne with zero = 1 → PCWrite = 1, PCSource = 01 for the first; PCWrite = 0 for the second. ALUSrcB = 10 in both DECODE states.
- opcode 0x3F → illegal = 1 in DECODE, one TRAP cycle, then FETCH with no RegWrite or PCWrite in between.
- reset asserted during the 2nd FETCH cycle → the next cycle is RST with all outputs 0, and IRWrite never pulses.
